// File: rtl/alu_pkg.sv
// alu_pkg: shared types and widths for the ALU port and its sequential driver.
// Opcode encoding, driver FSM states, and a saturating-increment helper
// used by the optional statistics counters (ALU_OP_DRIVER_STATS_EN).
package alu_pkg;

  localparam int ALU_W    = 8;
  localparam int ALU_OP_W = 3;
  localparam int STAT_W   = 16;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    NOT = 3'd5,
    SHL = 3'd6,
    SHR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } alu_drv_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alu_op_driver_stats.sv
// alu_op_driver_stats: three saturating event counters sampled on each
// response handshake of the driver. Only instantiated when
// ALU_OP_DRIVER_STATS_EN is defined.
module alu_op_driver_stats
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rsp_hs,
  input  logic              rsp_carry,
  input  logic              rsp_zero,
  output logic [STAT_W-1:0] stat_ops,
  output logic [STAT_W-1:0] stat_carry,
  output logic [STAT_W-1:0] stat_zero
);

  // Count handshakes, and those carrying a set carry/zero flag; hold at max.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops   <= '0;
      stat_carry <= '0;
      stat_zero  <= '0;
    end else if (rsp_hs) begin
      stat_ops <= sat_inc(stat_ops);
      if (rsp_carry) stat_carry <= sat_inc(stat_carry);
      if (rsp_zero)  stat_zero  <= sat_inc(stat_zero);
    end
  end

endmodule

// File: rtl/alu_op_driver.sv
// alu_op_driver: accepts one ALU command at a time, holds registered operands
// on the ALU port for SETTLE_CYCLES (legal 1..15), captures the result and
// flags, and offers them on a valid/ready response channel.
// Optional feature macro: ALU_OP_DRIVER_STATS_EN adds stat_ops/stat_carry/
// stat_zero saturating counters.
module alu_op_driver
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ALU_OP_W-1:0] cmd_opcode,
  input  logic [ALU_W-1:0]    cmd_a,
  input  logic [ALU_W-1:0]    cmd_b,
  output logic [ALU_W-1:0]    alu_a,
  output logic [ALU_W-1:0]    alu_b,
  output logic [ALU_OP_W-1:0] alu_opcode,
  input  logic [ALU_W-1:0]    alu_result,
  input  logic                alu_carry,
  input  logic                alu_negative,
  input  logic                alu_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ALU_W-1:0]    rsp_result,
  output logic                rsp_carry,
  output logic                rsp_negative,
  output logic                rsp_zero
`ifdef ALU_OP_DRIVER_STATS_EN
  ,
  output logic [STAT_W-1:0]   stat_ops,
  output logic [STAT_W-1:0]   stat_carry,
  output logic [STAT_W-1:0]   stat_zero
`endif
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  alu_drv_state_e state_q, state_d;
  logic [3:0]     cnt_q;
  logic           accept;
  logic           capture;
  logic           rsp_hs;

  // cmd_ready is held low while reset is asserted, even though state is IDLE.
  assign cmd_ready = rst_n && (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign capture   = (state_q == DRIVE) && (cnt_q == 4'd0);
  assign rsp_hs    = rsp_valid && rsp_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: accept -> settle -> wait for the response handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)  state_d = DRIVE;
      DRIVE:   if (capture) state_d = RESP;
      RESP:    if (rsp_hs)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Settle counter: loaded on acceptance, counts down to zero in DRIVE.
  always_ff @(posedge clk) begin
    if (!rst_n)                                   cnt_q <= 4'd0;
    else if (accept)                              cnt_q <= CNT_LOAD;
    else if (state_q == DRIVE && cnt_q != 4'd0)   cnt_q <= cnt_q - 4'd1;
  end

  // Operand/opcode registers feeding the ALU; only change on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else if (accept) begin
      alu_a      <= cmd_a;
      alu_b      <= cmd_b;
      alu_opcode <= cmd_opcode;
    end
  end

  // Response data registers; ALU values are copied verbatim on the capture edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_negative <= 1'b0;
      rsp_zero     <= 1'b0;
    end else if (capture) begin
      rsp_result   <= alu_result;
      rsp_carry    <= alu_carry;
      rsp_negative <= alu_negative;
      rsp_zero     <= alu_zero;
    end
  end

  // Response valid: raised on capture, dropped on the consumer handshake.
  always_ff @(posedge clk) begin
    if (!rst_n)       rsp_valid <= 1'b0;
    else if (capture) rsp_valid <= 1'b1;
    else if (rsp_hs)  rsp_valid <= 1'b0;
  end

`ifdef ALU_OP_DRIVER_STATS_EN
  alu_op_driver_stats u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .rsp_hs     (rsp_hs),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .stat_ops   (stat_ops),
    .stat_carry (stat_carry),
    .stat_zero  (stat_zero)
  );
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
// tb_alu_op_driver: two drivers (settle 1 and settle 4) each wired to a
// behavioural ALU; directed and randomized commands are checked against
// expected results, latency, stability under backpressure and reset.
module tb_alu_op_driver;

  localparam int S0 = 1;
  localparam int S1 = 4;

  logic       clk = 1'b0;
  logic       rst_n        [2];
  logic       cmd_valid    [2];
  logic       cmd_ready    [2];
  logic [2:0] cmd_opcode   [2];
  logic [7:0] cmd_a        [2];
  logic [7:0] cmd_b        [2];
  logic [7:0] alu_a        [2];
  logic [7:0] alu_b        [2];
  logic [2:0] alu_opcode   [2];
  logic [7:0] alu_result   [2];
  logic       alu_carry    [2];
  logic       alu_negative [2];
  logic       alu_zero     [2];
  logic       rsp_valid    [2];
  logic       rsp_ready    [2];
  logic [7:0] rsp_result   [2];
  logic       rsp_carry    [2];
  logic       rsp_negative [2];
  logic       rsp_zero     [2];
`ifdef ALU_OP_DRIVER_STATS_EN
  logic [15:0] stat_ops   [2];
  logic [15:0] stat_carry [2];
  logic [15:0] stat_zero  [2];
`endif
  logic [15:0] m_ops   [2];
  logic [15:0] m_carry [2];
  logic [15:0] m_zero  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: returns {result, carry, negative, zero}.
  function automatic logic [10:0] aluModel(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic       c;
    r = 8'h00;
    c = 1'b0;
    case (op)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; end
      3'd1: begin r = a - b; c = (a >= b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
      default: begin r = {1'b0, a[7:1]}; c = a[0]; end
    endcase
    return {r, c, r[7], (r == 8'h00)};
  endfunction

  assign {alu_result[0], alu_carry[0], alu_negative[0], alu_zero[0]} = aluModel(alu_opcode[0], alu_a[0], alu_b[0]);
  assign {alu_result[1], alu_carry[1], alu_negative[1], alu_zero[1]} = aluModel(alu_opcode[1], alu_a[1], alu_b[1]);

  alu_op_driver #(.SETTLE_CYCLES(S0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_opcode(cmd_opcode[0]), .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_opcode(alu_opcode[0]),
    .alu_result(alu_result[0]), .alu_carry(alu_carry[0]), .alu_negative(alu_negative[0]),
    .alu_zero(alu_zero[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_result(rsp_result[0]), .rsp_carry(rsp_carry[0]), .rsp_negative(rsp_negative[0]),
    .rsp_zero(rsp_zero[0])
`ifdef ALU_OP_DRIVER_STATS_EN
    , .stat_ops(stat_ops[0]), .stat_carry(stat_carry[0]), .stat_zero(stat_zero[0])
`endif
  );

  alu_op_driver #(.SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_opcode(cmd_opcode[1]), .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_opcode(alu_opcode[1]),
    .alu_result(alu_result[1]), .alu_carry(alu_carry[1]), .alu_negative(alu_negative[1]),
    .alu_zero(alu_zero[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_result(rsp_result[1]), .rsp_carry(rsp_carry[1]), .rsp_negative(rsp_negative[1]),
    .rsp_zero(rsp_zero[1])
`ifdef ALU_OP_DRIVER_STATS_EN
    , .stat_ops(stat_ops[1]), .stat_carry(stat_carry[1]), .stat_zero(stat_zero[1])
`endif
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check every driver output against its reset value.
  task automatic checkResetValues(input int d);
    checkOutput("rst_cmd_ready", 32'(cmd_ready[d]), 32'd0);
    checkOutput("rst_alu_a", 32'(alu_a[d]), 32'd0);
    checkOutput("rst_alu_b", 32'(alu_b[d]), 32'd0);
    checkOutput("rst_alu_opcode", 32'(alu_opcode[d]), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    checkOutput("rst_rsp_result", 32'(rsp_result[d]), 32'd0);
    checkOutput("rst_rsp_flags", {29'd0, rsp_carry[d], rsp_negative[d], rsp_zero[d]}, 32'd0);
`ifdef ALU_OP_DRIVER_STATS_EN
    checkOutput("rst_stat_ops", 32'(stat_ops[d]), 32'd0);
    checkOutput("rst_stat_carry", 32'(stat_carry[d]), 32'd0);
    checkOutput("rst_stat_zero", 32'(stat_zero[d]), 32'd0);
`endif
  endtask

  task automatic resetDut(input int d);
    rst_n[d]     = 1'b0;
    cmd_valid[d] = 1'b0;
    rsp_ready[d] = 1'b0;
    @(posedge clk); #1;
    m_ops[d] = 16'd0; m_carry[d] = 16'd0; m_zero[d] = 16'd0;
    checkResetValues(d);
    rst_n[d] = 1'b1;
    #1;
    checkOutput("post_rst_cmd_ready", 32'(cmd_ready[d]), 32'd1);
  endtask

  // Issue one command, check latency, backpressure stability and the response.
  task automatic applyStimulus(input int d, input logic [2:0] op, input logic [7:0] a,
                               input logic [7:0] b, input int hold, input logic [10:0] exp);
    int n;
    int lat;
    lat = (d == 0) ? S0 : S1;
    n = 0;
    while (cmd_ready[d] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    checkOutput("cmd_ready_wait", 32'(cmd_ready[d]), 32'd1);
    cmd_valid[d] = 1'b1; cmd_opcode[d] = op; cmd_a[d] = a; cmd_b[d] = b;
    @(posedge clk); #1;
    cmd_valid[d] = 1'b0;
    checkOutput("alu_a", 32'(alu_a[d]), 32'(a));
    checkOutput("alu_b", 32'(alu_b[d]), 32'(b));
    checkOutput("alu_opcode", 32'(alu_opcode[d]), 32'(op));
    checkOutput("busy_cmd_ready", 32'(cmd_ready[d]), 32'd0);
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checkOutput("rsp_latency", 32'(n), 32'(lat));
    // A competing command offered during backpressure must be ignored.
    cmd_valid[d] = (hold > 0); cmd_opcode[d] = ~op; cmd_a[d] = ~a; cmd_b[d] = ~b;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_rsp_valid", 32'(rsp_valid[d]), 32'd1);
      checkOutput("bp_rsp_result", 32'(rsp_result[d]), 32'(exp[10:3]));
      checkOutput("bp_alu_a", 32'(alu_a[d]), 32'(a));
      checkOutput("bp_alu_opcode", 32'(alu_opcode[d]), 32'(op));
      checkOutput("bp_cmd_ready", 32'(cmd_ready[d]), 32'd0);
    end
    cmd_valid[d] = 1'b0;
    checkOutput("rsp_result", 32'(rsp_result[d]), 32'(exp[10:3]));
    checkOutput("rsp_carry", 32'(rsp_carry[d]), 32'(exp[2]));
    checkOutput("rsp_negative", 32'(rsp_negative[d]), 32'(exp[1]));
    checkOutput("rsp_zero", 32'(rsp_zero[d]), 32'(exp[0]));
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    if (m_ops[d] != 16'hFFFF) m_ops[d] = m_ops[d] + 16'd1;
    if (exp[2] && m_carry[d] != 16'hFFFF) m_carry[d] = m_carry[d] + 16'd1;
    if (exp[0] && m_zero[d] != 16'hFFFF) m_zero[d] = m_zero[d] + 16'd1;
    checkOutput("post_hs_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    checkOutput("post_hs_cmd_ready", 32'(cmd_ready[d]), 32'd1);
    checkOutput("post_hs_rsp_hold", 32'(rsp_result[d]), 32'(exp[10:3]));
    checkOutput("post_hs_alu_a", 32'(alu_a[d]), 32'(a));
`ifdef ALU_OP_DRIVER_STATS_EN
    checkOutput("stat_ops", 32'(stat_ops[d]), 32'(m_ops[d]));
    checkOutput("stat_carry", 32'(stat_carry[d]), 32'(m_carry[d]));
    checkOutput("stat_zero", 32'(stat_zero[d]), 32'(m_zero[d]));
`endif
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; cmd_valid[d] = 1'b0; rsp_ready[d] = 1'b0;
      cmd_opcode[d] = 3'd0; cmd_a[d] = 8'd0; cmd_b[d] = 8'd0;
      m_ops[d] = 16'd0; m_carry[d] = 16'd0; m_zero[d] = 16'd0;
    end
    @(posedge clk); #1;
    resetDut(0);
    resetDut(1);

    $display("[TB] directed test-plan commands");
    applyStimulus(0, 3'd0, 8'hF0, 8'h20, 0, {8'h10, 1'b1, 1'b0, 1'b0});
    applyStimulus(0, 3'd1, 8'h05, 8'h05, 0, {8'h00, 1'b1, 1'b0, 1'b1});
    applyStimulus(0, 3'd1, 8'h03, 8'h05, 0, {8'hFE, 1'b0, 1'b1, 1'b0});
    applyStimulus(0, 3'd6, 8'h81, 8'h00, 0, {8'h02, 1'b1, 1'b0, 1'b0});
    applyStimulus(0, 3'd7, 8'h01, 8'h00, 0, {8'h00, 1'b1, 1'b0, 1'b1});
    applyStimulus(0, 3'd4, 8'hA5, 8'h0F, 5, {8'hAA, 1'b0, 1'b1, 1'b0});
    applyStimulus(1, 3'd0, 8'h7F, 8'h01, 5, {8'h80, 1'b0, 1'b1, 1'b0});

    $display("[TB] reset during DRIVE");
    cmd_valid[1] = 1'b1; cmd_opcode[1] = 3'd3; cmd_a[1] = 8'h3C; cmd_b[1] = 8'hC3;
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    @(posedge clk); #1;
    m_ops[1] = 16'd0; m_carry[1] = 16'd0; m_zero[1] = 16'd0;
    checkResetValues(1);
    rst_n[1] = 1'b1;
    for (int i = 0; i < S1 + 2; i++) begin
      @(posedge clk); #1;
      checkOutput("dropped_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    end
    applyStimulus(1, 3'd2, 8'hF0, 8'h3C, 0, {8'h30, 1'b0, 1'b0, 1'b0});

    $display("[TB] randomized commands");
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 20; i++) begin
        op = 3'($urandom_range(0, 7));
        a  = 8'($urandom);
        b  = 8'($urandom);
        applyStimulus(d, op, a, b, int'($urandom_range(0, 3)), aluModel(op, a, b));
      end
    end

`ifdef ALU_OP_DRIVER_STATS_EN
    $display("[TB] statistics saturation");
    @(negedge clk);
    force dut0.u_stats.stat_ops   = 16'hFFFE;
    force dut0.u_stats.stat_carry = 16'hFFFE;
    force dut0.u_stats.stat_zero  = 16'hFFFE;
    #1;
    release dut0.u_stats.stat_ops;
    release dut0.u_stats.stat_carry;
    release dut0.u_stats.stat_zero;
    m_ops[0] = 16'hFFFE; m_carry[0] = 16'hFFFE; m_zero[0] = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 3'd0, 8'hFF, 8'h01, 0, {8'h00, 1'b1, 1'b0, 1'b1});
      checkOutput("sat_stat_ops", 32'(stat_ops[0]), 32'hFFFF);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_driver.md
# alu_op_driver

- Sequential initiator for the team's combinational 8-bit ALU port (operands, opcode in; result, carry, negative, zero out).
- Accepts one command at a time over a valid/ready handshake and drives registered operands and opcode to the ALU.
- Waits a configurable settle time, then captures the ALU result and flags into registers.
- Presents the captured values on a valid/ready response channel. Sits between the command source (sequencer/testbench) and the ALU instance.

## Interface
- SETTLE_CYCLES, 1: cycles the ALU inputs are held before capture; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept a command.
- cmd_opcode  in  3  ALU operation (encoding in alu_pkg).
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- alu_a  out  8  registered operand A to ALU.
- alu_b  out  8  registered operand B to ALU.
- alu_opcode  out  3  registered opcode to ALU.
- alu_result  in  8  ALU result.
- alu_carry  in  1  ALU carry flag.
- alu_negative  in  1  ALU negative flag.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  captured response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  8  captured result.
- rsp_carry  out  1  captured carry.
- rsp_negative  out  1  captured negative.
- rsp_zero  out  1  captured zero.

## Operation
- FSM states: IDLE, DRIVE, RESP.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: register cmd_a/b/opcode into alu_a/b/opcode, load settle counter with SETTLE_CYCLES-1, go to DRIVE.
- **DRIVE**
  - cmd_ready=0; alu_* held stable.
  - Counter decrements each cycle.
  - On the edge where the counter is 0: capture alu_result/carry/negative/zero into the rsp_* registers, set rsp_valid, go to RESP.
- **RESP**
  - rsp_* and alu_* held stable while rsp_valid && !rsp_ready.
  - On rsp_valid&&rsp_ready: clear rsp_valid, go to IDLE.
  - rsp_* data keeps its last value after the handshake.
- Only one command is outstanding. No command is accepted in DRIVE or RESP.
- All 8 opcodes are legal. The driver never alters or interprets the flags; it passes the ALU values through verbatim.
- Reset values: cmd_ready=0 during reset and 1 after, in IDLE. alu_a=alu_b=0, alu_opcode=0. rsp_valid=0, rsp_result=0, rsp_carry=rsp_negative=rsp_zero=0. State=IDLE. Counter=0.
- Reset asserted in any state: the in-flight command is dropped, no response is produced, and all outputs return to their reset values on that edge.
- cmd_valid in DRIVE/RESP: ignored. The command source must hold it until accepted.

## Timing
- Edge E0 accepts a command; alu_* are valid from E0 onward.
- Capture happens at E0+SETTLE_CYCLES; rsp_valid is high from that edge onward.
- Minimum throughput: one command per SETTLE_CYCLES+2 cycles (accept, settle, response handshake with rsp_ready=1, return to IDLE).
- rsp_* change only on the capture edge or on reset.

## Configuration
- ALU_OP_DRIVER_STATS_EN defined:
  - Adds outputs stat_ops[15:0], stat_carry[15:0] and stat_zero[15:0].
  - stat_ops increments on every response handshake.
  - stat_carry increments on every response handshake with rsp_carry=1.
  - stat_zero increments on every response handshake with rsp_zero=1.
  - Each counter saturates at 0xFFFF; all reset to 0.
- Not defined: these ports and their logic are absent; behaviour is otherwise identical.

## Structure
- alu_pkg holds:
  - typedef enum alu_op_e: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SHL=6, SHR=7.
  - typedef enum alu_drv_state_e: IDLE, DRIVE, RESP.
  - localparam ALU_W=8, ALU_OP_W=3.
- Sub-module alu_op_driver_stats holds the three saturating counters; it is instantiated only under ALU_OP_DRIVER_STATS_EN.

## Test plan
- ADD: a=0xF0, b=0x20, rsp_ready=1, SETTLE_CYCLES=1 -> rsp_result=0x10, carry=1, negative=0, zero=0; rsp_valid rises 1 cycle after acceptance.
- SUB: a=0x05, b=0x05 -> result=0x00, carry=1, negative=0, zero=1. Then SUB a=0x03, b=0x05 -> result=0xFE, carry=0, negative=1.
- SHL: a=0x81 -> result=0x02, carry=1. Then SHR a=0x01 -> result=0x00, carry=1, zero=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_*, alu_* stable and cmd_ready=0 throughout; the next command is accepted only after the response handshake.
- Reset mid-DRIVE (SETTLE_CYCLES=4): assert rst_n=0 two cycles after acceptance -> no rsp_valid, all outputs at reset values, then the next command completes normally.
- ALU_OP_DRIVER_STATS_EN: preload via 0xFFFF handshakes (or force counters to 0xFFFE), run 3 ADD 0xFF+0x01 -> stat_ops=stat_carry=stat_zero=0xFFFF and they stay there.
